disp_seq_ctrl: RTL and testbench
================================

Name: disp_seq_ctrl

Overview:
Sequencing controller for the DDS front-panel display. It shares one six-digit active-low 7-segment bank between two value sources: the frequency word and the amplitude word. It schedules conversions on source update, source select change and a periodic refresh tick. Each conversion is an iterative 16-cycle double-dabble binary-to-BCD pass, followed by segment encoding into a 48-bit lights bus.

Parameters:
REFRESH_CYCLES, 5000000, clk cycles between periodic refresh ticks (10 Hz at 50 MHz); 0 disables refresh.

Ports:
clk  in  1  system clock, rising edge.
clr  in  1  reset; asynchronous, active-high.
sel  in  1  source select: 0 = frequency, 1 = amplitude.
freq_val  in  16  frequency value, unsigned.
freq_upd  in  1  one-cycle pulse: freq_val changed.
amp_val  in  16  amplitude value, unsigned.
amp_upd  in  1  one-cycle pulse: amp_val changed.
lights  out  48  segments, active-low, bit7 of each byte = decimal point. Byte 0 [7:0] = units, byte 4 [39:32] = ten-thousands, byte 5 [47:40] = source tag.
busy  out  1  conversion in progress.
done  out  1  one-cycle pulse when lights is updated.

Behaviour:
- Reset (clr high, asynchronous): lights = 48'hFFFFFFFFFFFF, busy = 0, done = 0, state = IDLE, refresh counter = 0, pending = 1 (forces the first conversion after release).
- Trigger sources:
  - freq_upd while sel = 0.
  - amp_upd while sel = 1.
  - Any change of sel versus its value on the previous cycle.
  - Refresh tick.
- Updates from the unselected source are ignored.
- All triggers OR into a single pending flag. Triggers arriving while busy coalesce, giving at most one follow-up conversion.
- Refresh counter: counts 0..REFRESH_CYCLES-1 continuously, and a tick fires on wrap.
- FSM states IDLE, SHIFT, ENCODE:
  - IDLE: if pending (or a trigger this cycle), latch the selected value and sel into working registers, clear pending, clear the 20-bit BCD accumulator, set cnt = 0, go to SHIFT.
  - SHIFT: for 16 cycles, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left 1. After cnt = 15, go to ENCODE.
  - ENCODE: write lights, assert done for one cycle, go to IDLE.
- A trigger in the same cycle as ENCODE sets pending.
- Latency: latch edge = edge 0, SHIFT on edges 1-16, lights and done registered on edge 17. busy = (state != IDLE), so it is high for 17 cycles.
- Value and sel are sampled only at the latch edge. Later changes wait for the next conversion.
- Digit encoding, active-low, dp off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=98.
- Leading-zero blanking:
  - Digits 4..1 display FF while they and all higher digits are 0.
  - The units digit is never blanked, so value 0 shows C0.
  - Zeros below the most significant non-zero digit are displayed.
- Tag byte: 8E ('F') when latched sel = 0, 88 ('A') when latched sel = 1.
- Range: 0..65535 inclusive, with no overflow. Maximum BCD value is 6_5535, so 20 bits suffice.
- clr mid-conversion: abort immediately, blank lights, and convert again after release (pending = 1).

Test Plan:
- clr pulse with freq_val = 0, sel = 0 -> lights = FFFF_FFFF_FFFF during reset. 17 cycles after release, lights = 8E_FF_FF_FF_FF_C0 and done pulses exactly once.
- freq_val = 12345 with freq_upd pulse -> busy high for 17 cycles, then lights = 8E_F9_A4_B0_99_92 and one done pulse.
- freq_val = 65535 -> lights = 8E_82_92_92_B0_92; freq_val = 10000 -> lights = 8E_F9_C0_C0_C0_C0 (internal zeros not blanked).
- amp_val = 907, then sel 0->1 (no amp_upd) -> conversion starts, lights = 88_FF_FF_98_C0_F8. A freq_upd pulse while sel = 1 produces no conversion.
- During busy, pulse freq_upd twice, then change freq_val to 42 -> exactly one follow-up conversion, showing 8E_FF_FF_FF_99_A4. No third done pulse.
- REFRESH_CYCLES = 100 in the bench with static inputs -> done every 100 cycles with unchanged lights. clr asserted at SHIFT cnt = 8 -> lights = all FF and busy = 0 asynchronously, then a full conversion runs after release.

Source files
------------

// File: rtl/disp_seq_ctrl.sv
// Display sequencer: shares one six-digit active-low 7-segment bank between freq and amp words.
// Latency: latch edge 0, 16 double-dabble SHIFT edges, lights/done registered on edge 17.
// Backpressure: triggers arriving while busy coalesce into one pending follow-up conversion.
module disp_seq_ctrl #(
    parameter int unsigned REFRESH_CYCLES = 5000000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        sel,
    input  logic [15:0] freq_val,
    input  logic        freq_upd,
    input  logic [15:0] amp_val,
    input  logic        amp_upd,
    output logic [47:0] lights,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

    localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REFRESH_LAST =
        (REFRESH_CYCLES == 0) ? '0 : RW'(REFRESH_CYCLES - 1);

    localparam logic [7:0] TAG_FREQ = 8'h8E;
    localparam logic [7:0] TAG_AMP  = 8'h88;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    state_t        state_q;
    logic [15:0]   bin_q;
    logic [19:0]   bcd_q;
    logic [3:0]    cnt_q;
    logic          src_q;
    logic          pending_q;
    logic          sel_prev_q;
    logic [RW-1:0] refresh_q;
    logic [47:0]   lights_q;
    logic          busy_q;
    logic          done_q;

    logic          refresh_tick;
    logic          trig;
    logic [19:0]   bcd_adj;
    logic [35:0]   dd_next;
    logic [47:0]   lights_d;

    // Active-low segment pattern for one BCD digit, decimal point off.
    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h98;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign refresh_tick = (REFRESH_CYCLES != 0) && (refresh_q == REFRESH_LAST);

    // Any trigger source; updates from the unselected source are ignored.
    assign trig = (freq_upd & ~sel) | (amp_upd & sel) | (sel != sel_prev_q) | refresh_tick;

    // Double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin} left by one.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        dd_next = {bcd_adj, bin_q} << 1;
    end

    // Segment encoding with leading-zero blanking; the units digit always shows.
    always_comb begin
        logic z4, z3, z2, z1;
        z4 = (bcd_q[19:16] == 4'd0);
        z3 = z4 && (bcd_q[15:12] == 4'd0);
        z2 = z3 && (bcd_q[11:8]  == 4'd0);
        z1 = z2 && (bcd_q[7:4]   == 4'd0);
        lights_d = {src_q ? TAG_AMP : TAG_FREQ,
                    z4 ? SEG_BLANK : seg7(bcd_q[19:16]),
                    z3 ? SEG_BLANK : seg7(bcd_q[15:12]),
                    z2 ? SEG_BLANK : seg7(bcd_q[11:8]),
                    z1 ? SEG_BLANK : seg7(bcd_q[7:4]),
                    seg7(bcd_q[3:0])};
    end

    // Free-running refresh counter and previous-select register for change detection.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            refresh_q  <= '0;
            sel_prev_q <= 1'b0;
        end else begin
            sel_prev_q <= sel;
            if (REFRESH_CYCLES == 0 || refresh_tick) begin
                refresh_q <= '0;
            end else begin
                refresh_q <= refresh_q + RW'(1);
            end
        end
    end

    // Conversion FSM: latch source, 16 shift steps, encode and publish lights.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            src_q     <= 1'b0;
            pending_q <= 1'b1;
            lights_q  <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pending_q || trig) begin
                        bin_q     <= sel ? amp_val : freq_val;
                        src_q     <= sel;
                        pending_q <= 1'b0;
                        bcd_q     <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    pending_q <= pending_q | trig;
                    bcd_q     <= dd_next[35:16];
                    bin_q     <= dd_next[15:0];
                    cnt_q     <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_q <= ENCODE;
                    end
                end
                ENCODE: begin
                    pending_q <= pending_q | trig;
                    lights_q  <= lights_d;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign lights = lights_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_disp_seq_ctrl.sv
// Directed bench for disp_seq_ctrl: main instance with refresh disabled, second with 100-cycle refresh.
// Expected light patterns are hand-computed segment codes.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_disp_seq_ctrl;

    localparam logic [47:0] ALL_FF = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] L0     = 48'h8EFFFFFFFFC0;
    localparam logic [47:0] L12345 = 48'h8EF9A4B09992;
    localparam logic [47:0] L65535 = 48'h8E829292B092;
    localparam logic [47:0] L10000 = 48'h8EF9C0C0C0C0;
    localparam logic [47:0] L907A  = 48'h88FFFF98C0F8;
    localparam logic [47:0] L555   = 48'h8EFFFF929292;
    localparam logic [47:0] L42    = 48'h8EFFFFFF99A4;

    logic        clk = 1'b0;
    logic        clr, sel, freq_upd, amp_upd;
    logic [15:0] freq_val, amp_val;
    logic [47:0] lights;
    logic        busy, done;

    logic        clr_r, sel_r, freq_upd_r, amp_upd_r;
    logic [15:0] freq_r, amp_r;
    logic [47:0] lights_r;
    logic        busy_r, done_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    disp_seq_ctrl #(.REFRESH_CYCLES(0)) dut (
        .clk(clk), .clr(clr), .sel(sel),
        .freq_val(freq_val), .freq_upd(freq_upd),
        .amp_val(amp_val), .amp_upd(amp_upd),
        .lights(lights), .busy(busy), .done(done)
    );

    disp_seq_ctrl #(.REFRESH_CYCLES(100)) dut_r (
        .clk(clk), .clr(clr_r), .sel(sel_r),
        .freq_val(freq_r), .freq_upd(freq_upd_r),
        .amp_val(amp_r), .amp_upd(amp_upd_r),
        .lights(lights_r), .busy(busy_r), .done(done_r)
    );

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done (bounded); n = edges until done, bc = samples with busy high.
    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = 0;
        for (int i = 1; i <= 60 && n == 0; i++) begin
            tick();
            if (busy) bc++;
            if (done) n = i;
        end
    endtask

    task automatic count_done(input int cyc, output int c);
        c = 0;
        for (int i = 0; i < cyc; i++) begin
            tick();
            if (done) c++;
        end
    endtask

    task automatic pulse_freq(input logic [15:0] v);
        freq_val = v;
        freq_upd = 1'b1;
        tick();
        freq_upd = 1'b0;
    endtask

    initial begin
        int n, bc, c, nd;
        logic [47:0] cap [2];
        int dpos [3];

        clr = 1'b0; sel = 1'b0; freq_val = '0; freq_upd = 1'b0; amp_val = '0; amp_upd = 1'b0;
        clr_r = 1'b0; sel_r = 1'b0; freq_r = 16'd12345; freq_upd_r = 1'b0; amp_r = '0; amp_upd_r = 1'b0;
        #1;
        clr = 1'b1;
        clr_r = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_lights", lights, ALL_FF);
        chk("rst_busy", {47'd0, busy}, 48'd0);
        chk("rst_done", {47'd0, done}, 48'd0);

        // First conversion forced by pending after release
        clr = 1'b0;
        wait_done(n, bc);
        chk("rst_latency", 48'(n), 48'd18);
        chk("rst_busy_cycles", 48'(bc), 48'd17);
        chk("zero_lights", lights, L0);
        count_done(30, c);
        chk("rst_single_done", 48'(c), 48'd0);

        // 12345
        pulse_freq(16'd12345);
        chk("busy_after_latch", {47'd0, busy}, 48'd1);
        wait_done(n, bc);
        chk("upd_latency", 48'(n), 48'd17);
        chk("upd_busy_cycles", 48'(bc + 1), 48'd17);
        chk("lights_12345", lights, L12345);
        count_done(20, c);
        chk("single_done_12345", 48'(c), 48'd0);

        // Boundary values
        pulse_freq(16'd65535);
        wait_done(n, bc);
        chk("lights_65535", lights, L65535);
        pulse_freq(16'd10000);
        wait_done(n, bc);
        chk("lights_10000", lights, L10000);

        // Select change alone starts an amplitude conversion
        amp_val = 16'd907;
        sel = 1'b1;
        wait_done(n, bc);
        chk("sel_latency", 48'(n), 48'd18);
        chk("lights_amp_907", lights, L907A);

        // Frequency update while amplitude selected is ignored
        pulse_freq(16'd555);
        chk("ignored_busy", {47'd0, busy}, 48'd0);
        count_done(30, c);
        chk("ignored_no_done", 48'(c), 48'd0);
        chk("ignored_lights", lights, L907A);

        // Back to frequency: conversion of 555, coalesced follow-up showing 42
        sel = 1'b0;
        tick();
        tick();
        freq_upd = 1'b1;
        tick();
        freq_upd = 1'b0;
        tick();
        freq_upd = 1'b1;
        tick();
        freq_upd = 1'b0;
        freq_val = 16'd42;
        nd = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (done) begin
                if (nd < 2) cap[nd] = lights;
                nd++;
            end
        end
        chk("coalesce_done_count", 48'(nd), 48'd2);
        chk("coalesce_first", cap[0], L555);
        chk("coalesce_second", cap[1], L42);

        // clr in the middle of SHIFT (cnt = 8)
        pulse_freq(16'd65535);
        for (int i = 0; i < 8; i++) tick();
        chk("mid_busy_before_clr", {47'd0, busy}, 48'd1);
        clr = 1'b1;
        #1;
        chk("mid_clr_lights", lights, ALL_FF);
        chk("mid_clr_busy", {47'd0, busy}, 48'd0);
        tick();
        clr = 1'b0;
        wait_done(n, bc);
        chk("mid_clr_restart_latency", 48'(n), 48'd18);
        chk("mid_clr_restart_lights", lights, L65535);

        // Periodic refresh on the second instance, static inputs
        clr_r = 1'b0;
        nd = 0;
        for (int i = 1; i <= 240; i++) begin
            tick();
            if (done_r) begin
                if (nd < 3) dpos[nd] = i;
                nd++;
                chk("refresh_lights", lights_r, L12345);
            end
        end
        chk("refresh_done_count", 48'(nd), 48'd3);
        if (nd >= 3) begin
            chk("refresh_first_done", 48'(dpos[0]), 48'd18);
            chk("refresh_period_1", 48'(dpos[1] - dpos[0]), 48'd99);
            chk("refresh_period_2", 48'(dpos[2] - dpos[1]), 48'd100);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
